// File: rtl/ysyx_24070016_mem_arbiter.sv
// ysyx_24070016_mem_arbiter: shares one data-memory port between the IFU (read-only)
// and the LSU (read/write) with round-robin arbitration and one outstanding transaction.
//
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   ifu_req_*/ifu_addr            IFU fetch request (valid/ready)
//   ifu_resp_*/ifu_rdata          IFU fetch response (valid/ready), raw word
//   lsu_req_*/lsu_wen/op/addr/wdata  LSU load/store request (valid/ready)
//   lsu_resp_*/lsu_rdata          LSU response, extended load data (0 for stores)
//   mem_req_*/mem_wen/addr/wdata/mask  memory request (valid/ready)
//   mem_resp_valid/mem_rdata      memory response pulse and raw low-aligned data
//   bus_err                       sticky flag set when a transaction times out
module ysyx_24070016_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [31:0]       ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [2:0]        lsu_op,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [31:0]       lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        mem_mask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_rdata,
  output logic              bus_err
);

  localparam int unsigned  CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic         OWN_IFU  = 1'b0;
  localparam logic         OWN_LSU  = 1'b1;
  localparam logic [2:0]   OP_W     = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  // Owner of the current transaction; doubles as the round-robin last grant.
  logic                owner_q, owner_d;
  logic [2:0]          op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [7:0]          mem_mask_q, mem_mask_d;
  logic                ifu_resp_valid_q, ifu_resp_valid_d;
  logic [31:0]         ifu_rdata_q, ifu_rdata_d;
  logic                lsu_resp_valid_q, lsu_resp_valid_d;
  logic [31:0]         lsu_rdata_q, lsu_rdata_d;
  logic                bus_err_q, bus_err_d;
  logic                grant_ifu_c;
  logic                resp_done_c;

  // Byte-lane mask encoding for an LSU op; illegal ops select no lane.
  function automatic logic [7:0] op_mask(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: op_mask = 8'h01;
      3'b001, 3'b101: op_mask = 8'h02;
      3'b010:         op_mask = 8'h04;
      default:        op_mask = 8'h00;
    endcase
  endfunction

  // Sign/zero extension of low-aligned load data; illegal ops return 0.
  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] raw);
    case (op)
      3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
      3'b010:  load_ext = raw;
      3'b100:  load_ext = {24'h0, raw[7:0]};
      3'b101:  load_ext = {16'h0, raw[15:0]};
      default: load_ext = 32'h0;
    endcase
  endfunction

  // IFU wins when alone or when the LSU was granted last.
  assign grant_ifu_c = ifu_req_valid && (!lsu_req_valid || (owner_q == OWN_LSU));
  assign resp_done_c = (owner_q == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

  // State register and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      owner_q          <= OWN_LSU;
      op_q             <= 3'b000;
      cnt_q            <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_wen_q        <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= 32'h0;
      mem_mask_q       <= 8'h00;
      ifu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= 32'h0;
      lsu_resp_valid_q <= 1'b0;
      lsu_rdata_q      <= 32'h0;
      bus_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      op_q             <= op_d;
      cnt_q            <= cnt_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_wen_q        <= mem_wen_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_mask_q       <= mem_mask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_rdata_q      <= ifu_rdata_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_rdata_q      <= lsu_rdata_d;
      bus_err_q        <= bus_err_d;
    end
  end

  // Next-state, latched fields and combinational request readies.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    op_d             = op_q;
    cnt_d            = cnt_q;
    mem_req_valid_d  = mem_req_valid_q;
    mem_wen_d        = mem_wen_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_mask_d       = mem_mask_q;
    ifu_resp_valid_d = ifu_resp_valid_q;
    ifu_rdata_d      = ifu_rdata_q;
    lsu_resp_valid_d = lsu_resp_valid_q;
    lsu_rdata_d      = lsu_rdata_q;
    bus_err_d        = bus_err_q;
    ifu_req_ready    = 1'b0;
    lsu_req_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_ifu_c) begin
          ifu_req_ready   = 1'b1;
          owner_d         = OWN_IFU;
          op_d            = OP_W;
          mem_req_valid_d = 1'b1;
          mem_wen_d       = 1'b0;
          mem_addr_d      = ifu_addr;
          mem_wdata_d     = 32'h0;
          mem_mask_d      = 8'h04;
          state_d         = S_ISSUE;
        end else if (lsu_req_valid) begin
          lsu_req_ready   = 1'b1;
          owner_d         = OWN_LSU;
          op_d            = lsu_op;
          mem_req_valid_d = 1'b1;
          mem_wen_d       = lsu_wen;
          mem_addr_d      = lsu_addr;
          mem_wdata_d     = lsu_wdata;
          mem_mask_d      = op_mask(lsu_op);
          state_d         = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          cnt_d           = '0;
          state_d         = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response in the timeout cycle still wins over the abort.
        if (mem_resp_valid || (cnt_q == CNT_LAST)) begin
          bus_err_d = bus_err_q | ~mem_resp_valid;
          state_d   = S_RESP;
          if (owner_q == OWN_IFU) begin
            ifu_resp_valid_d = 1'b1;
            ifu_rdata_d      = mem_resp_valid ? mem_rdata : 32'h0;
          end else begin
            lsu_resp_valid_d = 1'b1;
            lsu_rdata_d      = (mem_resp_valid && !mem_wen_q) ? load_ext(op_q, mem_rdata) : 32'h0;
          end
        end
      end

      S_RESP: begin
        if (resp_done_c) begin
          ifu_resp_valid_d = 1'b0;
          lsu_resp_valid_d = 1'b0;
          state_d          = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_rdata      = ifu_rdata_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_rdata      = lsu_rdata_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_wen        = mem_wen_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_mask       = mem_mask_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_ysyx_24070016_mem_arbiter.sv
// Bench for ysyx_24070016_mem_arbiter: directed requests, a memory responder and a
// response monitor; expected requests/responses are queued when stimulus is driven.
module tb_ysyx_24070016_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TMO    = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              ifu_req_valid, ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid, ifu_resp_ready;
  logic [31:0]       ifu_rdata;
  logic              lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [2:0]        lsu_op;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic              lsu_resp_valid, lsu_resp_ready;
  logic [31:0]       lsu_rdata;
  logic              mem_req_valid, mem_req_ready, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [7:0]        mem_mask;
  logic              mem_resp_valid;
  logic [31:0]       mem_rdata;
  logic              bus_err;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  mask;
  } req_t;

  typedef struct packed {
    logic        ifu;
    logic [31:0] data;
    logic        err;
  } resp_t;

  req_t  exp_req_q[$];
  resp_t exp_resp_q[$];

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc = 0, n_mem_hs = 0, n_resp = 0, hs_cyc = 0, resp_cyc = 0;
  int stall_cycles = 0, resp_lat = 0, late_req = 0;
  bit mute = 1'b0;
  logic [31:0] mem_data = 32'h0;

  ysyx_24070016_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_op(lsu_op), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: checks each offered request against the queue, then responds.
  initial begin : mem_model
    bit offered, pend;
    int stall, lat, late_done;
    req_t e;
    offered = 0; pend = 0; stall = 0; lat = 0; late_done = 0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      mem_resp_valid = 1'b0;
      if (reset) begin
        offered = 0; pend = 0; stall = 0; mem_req_ready = 1'b0; late_done = late_req;
      end else begin
        if (offered) begin
          offered = 0; mem_req_ready = 1'b0; stall = 0;
          n_mem_hs++; hs_cyc = cyc;
          if (exp_req_q.size() != 0) e = exp_req_q.pop_front();
          pend = !mute; lat = resp_lat;
        end
        if (pend) begin
          if (lat == 0) begin
            mem_resp_valid = 1'b1; mem_rdata = mem_data; pend = 0;
          end else lat--;
        end else if (late_done != late_req) begin
          mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0BAD0; late_done++;
        end
        if (mem_req_valid) begin
          chk("one_outstanding", 32'(pend), 32'd0);
          chk("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
          if (exp_req_q.size() != 0) begin
            e = exp_req_q[0];
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wen", 32'(mem_wen), 32'(e.wen));
            chk("mem_mask", 32'(mem_mask), 32'(e.mask));
            chk("mem_wdata", mem_wdata, e.wdata);
          end
          if (stall < stall_cycles) stall++;
          else begin
            mem_req_ready = 1'b1; offered = 1;
          end
        end
      end
    end
  end

  // Response monitor: pops the expected response and accepts it.
  initial begin : resp_mon
    resp_t s;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    forever begin
      @(negedge clock);
      ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
      if (!reset && (ifu_resp_valid || lsu_resp_valid)) begin
        resp_cyc = cyc;
        chk("resp_expected", 32'(exp_resp_q.size() != 0), 32'd1);
        if (exp_resp_q.size() != 0) begin
          s = exp_resp_q.pop_front();
          chk("resp_owner", 32'({ifu_resp_valid, lsu_resp_valid}), s.ifu ? 32'd2 : 32'd1);
          chk("resp_data", s.ifu ? ifu_rdata : lsu_rdata, s.data);
          chk("resp_bus_err", 32'(bus_err), 32'(s.err));
        end
        if (ifu_resp_valid) ifu_resp_ready = 1'b1;
        else lsu_resp_ready = 1'b1;
        n_resp++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_exp(input bit is_ifu, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [7:0] mask,
                          input logic [31:0] data, input logic err, input bit want_resp);
    req_t r;
    resp_t s;
    r.wen = wen; r.addr = addr; r.wdata = wdata; r.mask = mask;
    exp_req_q.push_back(r);
    if (want_resp) begin
      s.ifu = is_ifu; s.data = data; s.err = err;
      exp_resp_q.push_back(s);
    end
  endtask

  // Drives one request while the DUT is idle and checks the combinational grant.
  task automatic issue(input bit is_ifu, input logic wen, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] mask, input logic [31:0] data, input logic err,
                       input bit want_resp);
    push_exp(is_ifu, wen, addr, is_ifu ? 32'h0 : wdata, mask, data, err, want_resp);
    if (is_ifu) begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end else begin
      lsu_req_valid = 1'b1; lsu_wen = wen; lsu_op = op; lsu_addr = addr; lsu_wdata = wdata;
    end
    #1;
    chk("req_ready", 32'({ifu_req_ready, lsu_req_ready}), is_ifu ? 32'd2 : 32'd1);
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int i = 0;
    while (n_resp < target && i < 300) begin
      tick();
      i++;
    end
    chk("resp_arrived", 32'(n_resp >= target), 32'd1);
  endtask

  task automatic wait_hs(input int target);
    int i = 0;
    while (n_mem_hs < target && i < 300) begin
      tick();
      i++;
    end
    chk("mem_handshake", 32'(n_mem_hs >= target), 32'd1);
  endtask

  task automatic txn(input bit is_ifu, input logic wen, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [7:0] mask, input logic [31:0] rdata_in,
                     input logic [31:0] data, input logic err);
    int base;
    base = n_resp;
    mem_data = rdata_in;
    issue(is_ifu, wen, op, addr, wdata, mask, data, err, 1'b1);
    wait_resp(base + 1);
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int base;
    reset = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_op = 3'b000; lsu_addr = '0; lsu_wdata = 32'h0;
    do_reset();

    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_mask", 32'(mem_mask), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resp_valids", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    chk("rst_rdata", ifu_rdata | lsu_rdata, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    // IFU fetch with a 1-cycle memory response.
    txn(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 8'h04, 32'h0000_0013, 32'h0000_0013, 1'b0);
    chk("fetch_latency", 32'(resp_cyc - hs_cyc), 32'd1);

    // Loads: extension and masks.
    txn(1'b0, 1'b0, 3'b000, 32'h8000_0004, 32'h0, 8'h01, 32'h0000_00F0, 32'hFFFF_FFF0, 1'b0);
    txn(1'b0, 1'b0, 3'b100, 32'h8000_0004, 32'h0, 8'h01, 32'h0000_00F0, 32'h0000_00F0, 1'b0);
    txn(1'b0, 1'b0, 3'b001, 32'h8000_0004, 32'h0, 8'h02, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
    txn(1'b0, 1'b0, 3'b101, 32'h8000_0006, 32'h0, 8'h02, 32'h0000_8001, 32'h0000_8001, 1'b0);
    txn(1'b0, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 8'h04, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0);
    txn(1'b0, 1'b0, 3'b011, 32'h8000_000C, 32'h0, 8'h00, 32'h1234_5678, 32'h0000_0000, 1'b0);

    // Store with memory stalling the request for 3 cycles.
    stall_cycles = 3;
    txn(1'b0, 1'b1, 3'b010, 32'h8000_1000, 32'hDEAD_BEEF, 8'h04, 32'hCAFE_F00D, 32'h0, 1'b0);
    stall_cycles = 0;

    // Both requesters continuously valid from reset: IFU, LSU, IFU, LSU.
    do_reset();
    mem_data = 32'h1234_5678;
    base = n_resp;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_exp(1'b1, 1'b0, 32'h0000_1000, 32'h0, 8'h04, 32'h1234_5678, 1'b0, 1'b1);
      else push_exp(1'b0, 1'b0, 32'h0000_2000, 32'h55, 8'h04, 32'h1234_5678, 1'b0, 1'b1);
    end
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_op = 3'b010; lsu_addr = 32'h0000_2000;
    lsu_wdata = 32'h55;
    wait_resp(base + 4);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // Memory never answers: watchdog aborts after TMO wait cycles.
    mute = 1'b1;
    txn(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 8'h04, 32'h0, 32'h0, 1'b1);
    chk("timeout_latency", 32'(resp_cyc - hs_cyc), 32'(TMO));
    mute = 1'b0;
    late_req++;
    tick(); tick(); tick();
    chk("late_resp_ignored", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 8'h04, 32'h0000_0093, 32'h0000_0093, 1'b1);

    // Reset while waiting for memory: aborted LSU load never responds.
    resp_lat = 5;
    base = n_mem_hs;
    issue(1'b0, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 8'h04, 32'h0, 1'b0, 1'b0);
    wait_hs(base + 1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    resp_lat = 0;
    chk("rst_mid_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mid_resp_valids", 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    mem_data = 32'h0000_0037;
    base = n_resp;
    push_exp(1'b1, 1'b0, 32'h0000_5000, 32'h0, 8'h04, 32'h0000_0037, 1'b0, 1'b1);
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_5000;
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_op = 3'b010; lsu_addr = 32'h0000_6000;
    #1;
    chk("post_rst_grant", 32'({ifu_req_ready, lsu_req_ready}), 32'd2);
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    wait_resp(base + 1);
    tick(); tick();

    chk("req_q_drained", 32'(exp_req_q.size()), 32'd0);
    chk("resp_q_drained", 32'(exp_resp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
